// File: rtl/mux2_rr_arbiter_pkg.sv
// rtl/mux2_rr_arbiter_pkg.sv - shared state encodings and clog2 helper for the round-robin mux arbiter
package mux2_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } arb_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/mux2x1.sv
// rtl/mux2x1.sv - single-bit 2:1 mux cell with enable; output forced low when disabled
module mux2x1 (
  input  logic [1:0] x,
  input  logic       s,
  input  logic       en,
  output logic       y
);

  assign y = en & (s ? x[1] : x[0]);

endmodule

// File: rtl/mux2_rr_arbiter.sv
// rtl/mux2_rr_arbiter.sv - two-requester round-robin arbiter with bounded hold driving a shared 2:1 mux
module mux2_rr_arbiter
  import mux2_rr_arbiter_pkg::*;
#(
  parameter int W        = 4,
  parameter int MAX_HOLD = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req,
  input  logic [W-1:0] data0,
  input  logic [W-1:0] data1,
  output logic [1:0]   gnt,
  output logic         sel,
  output logic         en,
  output logic [W-1:0] y,
  output logic         preempt,
  output logic         busy
);

  localparam int HW = (clog2(MAX_HOLD) < 1) ? 1 : clog2(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  arb_state_e    state, state_nxt;
  logic [HW-1:0] hold_cnt;
  logic          last;
  logic          preempt_nxt;
  logic          entry;

  always_comb begin
    state_nxt   = state;
    preempt_nxt = 1'b0;
    case (state)
      IDLE: begin
        case (req)
          2'b01:   state_nxt = G0;
          2'b10:   state_nxt = G1;
          2'b11:   state_nxt = last ? G0 : G1;
          default: state_nxt = IDLE;
        endcase
      end
      G0: begin
        // A release in the preemption cycle wins: it is a voluntary handover.
        if (!req[0]) begin
          state_nxt = req[1] ? G1 : IDLE;
        end else if (req[1] && hold_cnt == HOLD_LAST) begin
          state_nxt   = G1;
          preempt_nxt = 1'b1;
        end
      end
      G1: begin
        if (!req[1]) begin
          state_nxt = req[0] ? G0 : IDLE;
        end else if (req[0] && hold_cnt == HOLD_LAST) begin
          state_nxt   = G0;
          preempt_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign entry = (state_nxt != state) && (state_nxt != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      hold_cnt <= '0;
      last     <= 1'b1;
      preempt  <= 1'b0;
    end else begin
      state   <= state_nxt;
      preempt <= preempt_nxt;
      if (entry) begin
        hold_cnt <= '0;
        last     <= (state_nxt == G1);
      end else if (state != IDLE && hold_cnt != HOLD_LAST) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

  assign gnt  = {state == G1, state == G0};
  assign sel  = (state == G1);
  assign en   = (state != IDLE);
  assign busy = en;

  for (genvar b = 0; b < W; b++) begin : g_bit
    mux2x1 u_mux (
      .x  ({data1[b], data0[b]}),
      .s  (sel),
      .en (en),
      .y  (y[b])
    );
  end

endmodule

// File: doc/mux2_rr_arbiter.md
Name: mux2_rr_arbiter

Overview:
Shares one 2:1 mux datapath between two requesters using round-robin arbitration with a bounded hold time. The block registers the grant and drives the mux select and enable. It instantiates the team's mux2x1 cell per data bit, so y carries the granted requester's data. It sits between two producers and a single shared consumer bus.

Parameters:
W, 4, data width per requester (≥1)
MAX_HOLD, 4, max consecutive grant cycles when the other side is waiting (≥1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
req  input  2  request per requester; req[i] held high while it wants the bus
data0  input  W  requester 0 data
data1  input  W  requester 1 data
gnt  output  2  one-hot grant, registered; 00 when idle
sel  output  1  mux select, registered; 1 iff gnt==10
en  output  1  mux enable, registered; 1 iff gnt!=00
y  output  W  mux output; data of granted requester, 0 when en=0
preempt  output  1  one-cycle pulse on the first cycle of a grant taken by hold-limit preemption
busy  output  1  equals en

Behaviour:
- One clock (clk); reset asynchronous, active-high (rst). While rst=1, outputs are forced immediately, with no clock edge needed: gnt=00, sel=0, en=0, y=0, preempt=0, busy=0. Internal reset values: state=IDLE, hold_cnt=0, last=1, so requester 0 wins the first tie.
- States: IDLE, G0, G1. gnt, sel and en decode from the state register. y is combinational from data0/data1 through the mux cells; it is valid in the same cycle as gnt.
- Latency: a request sampled at edge N gives a grant visible after edge N. Minimum 1 cycle.
- IDLE:
  - req==01 → G0.
  - req==10 → G1.
  - req==11 → grant the requester ≠ last.
  - req==00 → stay in IDLE.
- Gi, where j is the other requester:
  - req[i]=0 and req[j]=1 → Gj next cycle, with no IDLE bubble.
  - req[i]=0 and req[j]=0 → IDLE.
  - req[i]=1, req[j]=1 and hold_cnt==MAX_HOLD-1 → Gj, and preempt=1 for that first Gj cycle.
  - Otherwise → stay in Gi.
- hold_cnt:
  - Width clog2(MAX_HOLD), minimum 1 bit.
  - Cleared to 0 on every entry into G0 or G1.
  - Increments each cycle in Gi; saturates at MAX_HOLD-1.
  - With req[j]=0, saturation does not release the grant.
- last is updated to i on every entry into Gi.
- MAX_HOLD=1 with req==11 continuously: the grant alternates every cycle, and preempt=1 on every switch.
- preempt is a registered single-cycle pulse. It stays 0 for voluntary handovers and IDLE grants.
- A requester dropping req in the same cycle it would be preempted counts as a voluntary release: preempt=0.
- Reset asserted mid-grant: the grant is lost immediately. After release, the first tie goes to requester 0.

Decomposition:
- Shared package or header holds: state encodings (IDLE=2'd0, G0=2'd1, G1=2'd2) and a clog2 helper.
- Natural sub-module: the existing mux2x1 cell (ports x[1:0], s, en, y), generate-instantiated W times.
  - Per bit b: x={data1[b],data0[b]}, s=sel, en=en.
- Arbiter FSM and counter stay in the top module.

Test Plan:
1. Single request, W=4, data0=4'hA: req=01 before edge 1 → gnt=01, sel=0, en=1, y=4'hA after edge 1; req=00 before edge 5 → gnt=00, y=4'h0 after edge 5.
2. Tie from reset, MAX_HOLD=4, data0=4'h3, data1=4'hC, req=11 held: gnt=01 for 4 cycles (y=3), then gnt=10 for 4 cycles (y=C) with preempt=1 on its first cycle only, then back to 01 with preempt pulse.
3. Voluntary handover: in G0 with req=11 and hold_cnt=1, drop req[0] → gnt=10 next cycle, preempt=0, no idle cycle between.
4. Saturation: req=10 held 20 cycles, MAX_HOLD=4 → gnt=10 throughout, preempt never 1.
5. Round-robin memory: G1 completes, req=00 for 3 cycles, then req=11 → gnt=01; repeat after a G0 grant → gnt=10.
6. Async reset mid-grant: in G1, raise rst between edges → gnt=00, en=0, y=0 immediately; release rst, req=11 → gnt=01 first.
